// File: rtl/package_settings.sv
// Project-wide data widths shared by the filter chain and its controllers.
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/v4_parameters.sv
// Controller state encoding, warm-up length and power-on configuration.
package v4_parameters;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    ARMED = 3'd2,
    PEAK  = 3'd3,
    DEAD  = 3'd4,
    REARM = 3'd5
  } ctrl_state_t;

  localparam int FLUSH_LEN_DEFAULT = 64;

  localparam logic signed [package_settings::SIZE_FILTER_DATA-1:0] RST_THRESHOLD =
    package_settings::SIZE_FILTER_DATA'(100);
  localparam logic [7:0] RST_WINDOW = 8'd16;
  localparam logic [7:0] RST_DEAD   = 8'd32;

  // A zero-length window still searches the trigger sample's pulse for one cycle.
  function automatic logic [7:0] win_len(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction
endpackage

// File: rtl/v4_filter_ctrl_if.sv
// Config and event channels of the trigger controller.
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both 1; a raised valid holds its payload until that edge.
interface v4_filter_ctrl_if #(
  parameter int TS_W = 32
);
  logic                                           cfg_valid;
  logic                                           cfg_ready;
  logic signed [package_settings::SIZE_FILTER_DATA-1:0] cfg_threshold;
  logic [7:0]                                     cfg_window;
  logic [7:0]                                     cfg_dead;
  logic                                           ev_valid;
  logic                                           ev_ready;
  logic signed [package_settings::SIZE_FILTER_DATA-1:0] ev_amp;
  logic [TS_W-1:0]                                ev_time;

  modport master (
    output cfg_valid, cfg_threshold, cfg_window, cfg_dead, ev_ready,
    input  cfg_ready, ev_valid, ev_amp, ev_time
  );

  modport slave (
    input  cfg_valid, cfg_threshold, cfg_window, cfg_dead, ev_ready,
    output cfg_ready, ev_valid, ev_amp, ev_time
  );
endinterface

// File: rtl/v4_event_reg.sv
// Single-entry event holding register; a push that finds the slot occupied
// and not draining is dropped and counted.
module v4_event_reg #(
  parameter int AMP_W = 16,
  parameter int TS_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic signed [AMP_W-1:0] i_amp,
  input  logic [TS_W-1:0]         i_time,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic signed [AMP_W-1:0] o_amp,
  output logic [TS_W-1:0]         o_time,
  output logic [15:0]             o_lost_cnt
);
  logic                    r_valid;
  logic signed [AMP_W-1:0] r_amp;
  logic [TS_W-1:0]         r_time;
  logic [15:0]             r_lost;
  logic                    w_accept;

  assign w_accept = i_push && (!r_valid || i_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_amp   <= '0;
      r_time  <= '0;
      r_lost  <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_amp   <= i_amp;
        r_time  <= i_time;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_push && !w_accept && (r_lost != 16'hFFFF)) begin
        r_lost <= r_lost + 16'd1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_amp      = r_amp;
  assign o_time     = r_time;
  assign o_lost_cnt = r_lost;
endmodule

// File: rtl/v4_filter_ctrl.sv
// Threshold trigger / peak-search controller sitting behind a pulse filter.
// Holds the filter in reset while idle, flushes it, then emits {peak, time} events.
module v4_filter_ctrl
  import v4_parameters::*;
#(
  parameter int FLUSH_LEN = FLUSH_LEN_DEFAULT,
  parameter int TS_W      = 32
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic signed [package_settings::SIZE_FILTER_DATA-1:0] filt_data,
  output logic                                            filt_rst_n,
  output logic                                            busy,
  output logic [15:0]                                     lost_cnt,
  output ctrl_state_t                                     dbg_state,
  v4_filter_ctrl_if.slave                                 bus
);
  localparam int DW = package_settings::SIZE_FILTER_DATA;

  ctrl_state_t           r_state;
  ctrl_state_t           w_next;
  logic [TS_W-1:0]       r_ts;
  logic [TS_W-1:0]       r_trig_ts;
  logic signed [DW-1:0]  r_thr;
  logic [7:0]            r_win;
  logic [7:0]            r_dead;
  logic [15:0]           r_cnt;
  logic [7:0]            r_wcnt;
  logic signed [DW-1:0]  r_peak;
  logic signed [DW-1:0]  w_peak_upd;
  logic                  w_push;

  // Strict compare keeps the first maximum on ties.
  assign w_peak_upd = (filt_data > r_peak) ? filt_data : r_peak;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      IDLE:  if (enable) w_next = FLUSH;
      FLUSH: if (r_cnt == 16'(FLUSH_LEN - 1)) w_next = ARMED;
      ARMED: if (filt_data > r_thr) w_next = PEAK;
      PEAK: begin
        if (r_wcnt <= 8'd1) begin
          w_push = 1'b1;
          w_next = (r_dead == 8'd0) ? REARM : DEAD;
        end
      end
      DEAD:  if (r_cnt == ({8'd0, r_dead} - 16'd1)) w_next = REARM;
      REARM: if (filt_data <= r_thr) w_next = ARMED;
      default: w_next = IDLE;
    endcase
    // Dropping enable abandons any search in progress without counting a loss.
    if ((r_state != IDLE) && !enable) begin
      w_next = IDLE;
      w_push = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts      <= '0;
      r_trig_ts <= '0;
      r_thr     <= RST_THRESHOLD;
      r_win     <= RST_WINDOW;
      r_dead    <= RST_DEAD;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_peak    <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if ((r_state == IDLE) && bus.cfg_valid) begin
        r_thr  <= bus.cfg_threshold;
        r_win  <= bus.cfg_window;
        r_dead <= bus.cfg_dead;
      end
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == FLUSH) || (r_state == DEAD)) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if ((r_state == ARMED) && (w_next == PEAK)) begin
        r_peak    <= filt_data;
        r_trig_ts <= r_ts;
        r_wcnt    <= win_len(r_win);
      end else if ((r_state == PEAK) && (w_next == PEAK)) begin
        r_peak <= w_peak_upd;
        r_wcnt <= r_wcnt - 8'd1;
      end
    end
  end

  v4_event_reg #(
    .AMP_W (DW),
    .TS_W  (TS_W)
  ) u_event_reg (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_amp      (w_peak_upd),
    .i_time     (r_trig_ts),
    .i_ready    (bus.ev_ready),
    .o_valid    (bus.ev_valid),
    .o_amp      (bus.ev_amp),
    .o_time     (bus.ev_time),
    .o_lost_cnt (lost_cnt)
  );

  assign bus.cfg_ready = (r_state == IDLE);
  assign filt_rst_n    = (r_state != IDLE);
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_v4_filter_ctrl.sv
// Directed bench for v4_filter_ctrl: flush, trigger/peak, drop, enable abort,
// reconfiguration with negative threshold, and reset during an active search.
module tb_v4_filter_ctrl;
  import v4_parameters::*;

  localparam int DW = package_settings::SIZE_FILTER_DATA;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic signed [DW-1:0] filt_data;
  logic                 filt_rst_n;
  logic                 busy;
  logic [15:0]          lost_cnt;
  ctrl_state_t          dbg_state;

  int n_vec;
  int n_err;
  int ts_m;
  int t_trig;

  v4_filter_ctrl_if #(.TS_W(32)) bus_if ();

  v4_filter_ctrl #(
    .FLUSH_LEN (64),
    .TS_W      (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .filt_data  (filt_data),
    .filt_rst_n (filt_rst_n),
    .busy       (busy),
    .lost_cnt   (lost_cnt),
    .dbg_state  (dbg_state),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input ctrl_state_t exp);
    chk(tag, 32'(dbg_state), 32'(exp));
  endtask

  // One rising edge; ts_m follows the free-running timestamp.
  task automatic step();
    @(posedge clk);
    if (reset) ts_m = 0;
    else       ts_m = ts_m + 1;
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic feed(input int d);
    filt_data = DW'(d);
    step();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk_state({pfx, "_state"}, IDLE);
    chk({pfx, "_filt_rst_n"}, 32'(filt_rst_n), 32'd0);
    chk({pfx, "_cfg_ready"}, 32'(bus_if.cfg_ready), 32'd1);
    chk({pfx, "_ev_valid"}, 32'(bus_if.ev_valid), 32'd0);
    chk({pfx, "_ev_amp"}, 32'(bus_if.ev_amp), 32'd0);
    chk({pfx, "_ev_time"}, bus_if.ev_time, 32'd0);
    chk({pfx, "_lost_cnt"}, 32'(lost_cnt), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ts_m  = 0;
    reset = 1'b1;
    enable = 1'b0;
    filt_data = '0;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_threshold = '0;
    bus_if.cfg_window = 8'd0;
    bus_if.cfg_dead = 8'd0;
    bus_if.ev_ready = 1'b0;

    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Config handshake in the same edge as the enable.
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_threshold = DW'(100);
    bus_if.cfg_window = 8'd4;
    bus_if.cfg_dead = 8'd2;
    enable = 1'b1;
    step();
    chk_state("flush_entry", FLUSH);
    chk("flush_filt_rst_n", 32'(filt_rst_n), 32'd1);
    chk("flush_cfg_ready", 32'(bus_if.cfg_ready), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_threshold = '0;
    bus_if.cfg_window = 8'd0;
    filt_data = DW'(500);
    step_n(63);
    chk_state("flush_last", FLUSH);
    step();
    chk_state("armed_at_64", ARMED);

    // Single pulse, output free.
    bus_if.ev_ready = 1'b1;
    feed(50);
    chk_state("below_thr", ARMED);
    t_trig = ts_m;
    feed(150);
    chk_state("trig", PEAK);
    feed(300);
    feed(300);
    feed(200);
    chk("no_early_ev", 32'(bus_if.ev_valid), 32'd0);
    feed(50);
    chk("ev1_valid", 32'(bus_if.ev_valid), 32'd1);
    chk("ev1_amp", 32'(bus_if.ev_amp), 32'd300);
    chk("ev1_time", bus_if.ev_time, 32'(t_trig));
    chk_state("ev1_dead", DEAD);
    feed(50);
    chk("ev1_clear", 32'(bus_if.ev_valid), 32'd0);
    chk_state("dead_2nd", DEAD);
    feed(50);
    chk_state("rearm", REARM);
    feed(50);
    chk_state("rearmed", ARMED);

    // Two pulses with the consumer stalled.
    bus_if.ev_ready = 1'b0;
    t_trig = ts_m;
    feed(120);
    feed(400);
    feed(250);
    feed(60);
    feed(60);
    chk("evA_valid", 32'(bus_if.ev_valid), 32'd1);
    chk("evA_amp", 32'(bus_if.ev_amp), 32'd400);
    feed(60);
    feed(60);
    feed(60);
    chk_state("evA_rearmed", ARMED);
    feed(200);
    feed(90);
    feed(90);
    feed(90);
    feed(90);
    chk("drop_lost", 32'(lost_cnt), 32'd1);
    chk("hold_valid", 32'(bus_if.ev_valid), 32'd1);
    chk("hold_amp", 32'(bus_if.ev_amp), 32'd400);
    chk("hold_time", bus_if.ev_time, 32'(t_trig));
    bus_if.ev_ready = 1'b1;
    feed(50);
    chk("drain_clear", 32'(bus_if.ev_valid), 32'd0);
    feed(50);
    feed(50);
    chk_state("drain_armed", ARMED);

    // Enable dropped mid-search.
    feed(150);
    feed(300);
    chk_state("abort_peak", PEAK);
    enable = 1'b0;
    feed(300);
    chk_state("abort_idle", IDLE);
    chk("abort_filt_rst_n", 32'(filt_rst_n), 32'd0);
    chk("abort_lost", 32'(lost_cnt), 32'd1);
    step_n(5);
    chk("abort_no_ev", 32'(bus_if.ev_valid), 32'd0);

    // Negative threshold, zero window, zero dead time.
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_threshold = -DW'(20);
    bus_if.cfg_window = 8'd0;
    bus_if.cfg_dead = 8'd0;
    step();
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_threshold = '0;
    enable = 1'b1;
    filt_data = '0;
    step();
    step_n(64);
    chk_state("neg_armed", ARMED);
    feed(-20);
    chk_state("neg_strict", ARMED);
    t_trig = ts_m;
    feed(-19);
    chk_state("neg_trig", PEAK);
    feed(200);
    chk("w1_valid", 32'(bus_if.ev_valid), 32'd1);
    chk("w1_amp", 32'(bus_if.ev_amp), 32'd200);
    chk("w1_time", bus_if.ev_time, 32'(t_trig));
    chk_state("dead0_rearm", REARM);
    feed(200);
    chk("w1_clear", 32'(bus_if.ev_valid), 32'd0);
    feed(200);
    feed(200);
    chk_state("rearm_hold", REARM);
    feed(-20);
    chk_state("rearm_release", ARMED);

    // Reset while searching with an event pending.
    bus_if.ev_ready = 1'b0;
    feed(-10);
    feed(5);
    feed(-30);
    feed(7);
    chk_state("pre_rst_peak", PEAK);
    chk("pre_rst_valid", 32'(bus_if.ev_valid), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;

    // Power-on config: threshold 100, window 16, dead 32.
    filt_data = '0;
    step();
    step_n(64);
    chk_state("def_armed", ARMED);
    feed(100);
    chk_state("def_thr", ARMED);
    t_trig = ts_m;
    feed(101);
    chk_state("def_trig", PEAK);
    bus_if.ev_ready = 1'b1;
    step_n(15);
    chk_state("def_win15", PEAK);
    chk("def_no_ev", 32'(bus_if.ev_valid), 32'd0);
    step();
    chk_state("def_win16", DEAD);
    chk("def_valid", 32'(bus_if.ev_valid), 32'd1);
    chk("def_amp", 32'(bus_if.ev_amp), 32'd101);
    chk("def_time", bus_if.ev_time, 32'(t_trig));
    step_n(31);
    chk_state("def_dead31", DEAD);
    step();
    chk_state("def_dead32", REARM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
